// File: rtl/riscv_test_pkg.sv
// Shared state encoding, default riscv-tests register indices and flag decode for the test monitor.
// Pure definitions: no latency, no backpressure.
package riscv_test_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_PASS   = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;
    localparam logic [2:0] S_TMO    = 3'd5;

    localparam int RV_TEST_DONE = 26;
    localparam int RV_TEST_PASS = 27;
    localparam int RV_TEST_TNUM = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_RUN    = S_RUN,
        ST_SETTLE = S_SETTLE,
        ST_PASS   = S_PASS,
        ST_FAIL   = S_FAIL,
        ST_TMO    = S_TMO
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic pass;
        logic fail;
        logic timeout;
    } flags_t;

    function automatic flags_t decode_flags(input state_t s);
        flags_t f;
        f.busy    = (s == ST_RUN) || (s == ST_SETTLE);
        f.pass    = (s == ST_PASS);
        f.fail    = (s == ST_FAIL);
        f.timeout = (s == ST_TMO);
        f.done    = f.pass || f.fail || f.timeout;
        return f;
    endfunction

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Saturating up-counter used for the verdict tallies; count updates one cycle after inc.
// Holds at all-ones instead of wrapping; no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// Snoops register-file writes for riscv-tests done/pass/testnum and holds a pass/fail/timeout verdict.
// Verdict flags appear SETTLE_CYCLES+1 cycles after the done write; passive observer, no backpressure.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int          DATA_W         = 32,
    parameter int          REG_ADDR_W     = 5,
    parameter int          DONE_REG       = RV_TEST_DONE,
    parameter int          PASS_REG       = RV_TEST_PASS,
    parameter int          TNUM_REG       = RV_TEST_TNUM,
    parameter int          SETTLE_CYCLES  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int          CNT_W          = 32,
    parameter int          RES_W          = 8,
    parameter int          AUTO_START     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]     wb_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [DATA_W-1:0]     fail_testnum,
    output logic [CNT_W-1:0]      cycles,
    output logic [RES_W-1:0]      pass_cnt,
    output logic [RES_W-1:0]      fail_cnt
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0]      SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      TMO_LAST    = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [REG_ADDR_W-1:0] DONE_A      = REG_ADDR_W'(DONE_REG);
    localparam logic [REG_ADDR_W-1:0] PASS_A      = REG_ADDR_W'(PASS_REG);
    localparam logic [REG_ADDR_W-1:0] TNUM_A      = REG_ADDR_W'(TNUM_REG);
    localparam logic [DATA_W-1:0]     ONE         = DATA_W'(1);
    localparam state_t                RESET_STATE = (AUTO_START != 0) ? ST_RUN : ST_IDLE;

    state_t            state;
    state_t            next_state;
    flags_t            flags;
    logic [DATA_W-1:0] shadow_done;
    logic [DATA_W-1:0] shadow_pass;
    logic [DATA_W-1:0] shadow_tnum;
    logic [SET_W-1:0]  settle_cnt;

    logic wr_ok;
    logic done_hit;
    logic tmo_hit;
    logic enter_verdict;
    logic pass_inc;
    logic fail_inc;

    // x0 writes never land, and a write colliding with start belongs to the old test.
    assign wr_ok    = wb_we && (wb_waddr != '0) && !start;
    assign done_hit = (wr_ok && (wb_waddr == DONE_A) && (wb_wdata == ONE)) || (shadow_done == ONE);
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cycles == TMO_LAST);

    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (done_hit) begin
                        next_state = ST_SETTLE;
                    end else if (tmo_hit) begin
                        next_state = ST_TMO;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        next_state = (shadow_pass == ONE) ? ST_PASS : ST_FAIL;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    assign enter_verdict = !start && ((state == ST_RUN) || (state == ST_SETTLE))
                           && ((next_state == ST_PASS) || (next_state == ST_FAIL) || (next_state == ST_TMO));
    assign pass_inc      = enter_verdict && (next_state == ST_PASS);
    assign fail_inc      = enter_verdict && (next_state != ST_PASS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RESET_STATE;
            flags <= '0;
        end else begin
            state <= next_state;
            flags <= decode_flags(next_state);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_done <= '0;
            shadow_pass <= '0;
            shadow_tnum <= '0;
        end else if (start) begin
            shadow_done <= '0;
            shadow_pass <= '0;
            shadow_tnum <= '0;
        end else if (wr_ok) begin
            if (wb_waddr == DONE_A) shadow_done <= wb_wdata;
            if (wb_waddr == PASS_A) shadow_pass <= wb_wdata;
            if (wb_waddr == TNUM_A) shadow_tnum <= wb_wdata;
        end
    end

    // The timeout edge itself is not counted so cycles holds the cycle the limit hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles       <= '0;
            settle_cnt   <= '0;
            fail_testnum <= '0;
        end else if (start) begin
            cycles       <= '0;
            settle_cnt   <= '0;
            fail_testnum <= '0;
        end else begin
            if (((state == ST_RUN) && (next_state != ST_TMO)) || (state == ST_SETTLE)) begin
                cycles <= cycles + CNT_W'(1);
            end
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SET_W'(1) : '0;
            if (enter_verdict) begin
                fail_testnum <= shadow_tnum;
            end
        end
    end

    sat_counter #(.W(RES_W)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (pass_inc),
        .count (pass_cnt)
    );

    sat_counter #(.W(RES_W)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (fail_inc),
        .count (fail_cnt)
    );

    assign busy    = flags.busy;
    assign done    = flags.done;
    assign pass    = flags.pass;
    assign fail    = flags.fail;
    assign timeout = flags.timeout;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: verdicts are checked by a scoreboard fed from the stimulus.
// Cycle N means the clock period in which the monitor's cycles output reads N.
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_waddr = '0;
    logic [31:0] wb_wdata = '0;
    logic        busy, done, pass, fail, timeout;
    logic [31:0] fail_testnum;
    logic [31:0] cycles;
    logic [7:0]  pass_cnt, fail_cnt;

    int tests = 0;
    int fails = 0;
    int cyc;

    typedef struct {
        logic        pass;
        logic        fail;
        logic        timeout;
        logic [31:0] tnum;
        logic [31:0] cycles;
        logic [7:0]  pass_cnt;
        logic [7:0]  fail_cnt;
        int          at;
    } verdict_t;

    verdict_t exp_q[$];

    riscv_test_monitor #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .wb_we        (wb_we),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .fail_testnum (fail_testnum),
        .cycles       (cycles),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst)       cyc <= 0;
        else if (start) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc < c && n < 2000) begin
            step();
            n++;
        end
        if (cyc < c) begin
            tests++;
            fails++;
            $display("FAIL wait_cyc: stuck at cycle %0d, expected to reach %0d", cyc, c);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
        step();
        wb_we = 1'b0;
        wb_waddr = '0;
        wb_wdata = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic expect_v(input logic p, input logic f, input logic t, input logic [31:0] tn,
                            input logic [31:0] cy, input logic [7:0] pc, input logic [7:0] fc, input int at);
        verdict_t v;
        v.pass = p; v.fail = f; v.timeout = t; v.tnum = tn;
        v.cycles = cy; v.pass_cnt = pc; v.fail_cnt = fc; v.at = at;
        exp_q.push_back(v);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".done"}, done, 0);
        check({tag, ".pass"}, pass, 0);
        check({tag, ".fail"}, fail, 0);
        check({tag, ".fail_testnum"}, fail_testnum, 0);
        check({tag, ".busy"}, busy, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".pass"}, pass, 0);
        check({tag, ".fail"}, fail, 0);
        check({tag, ".timeout"}, timeout, 0);
        check({tag, ".fail_testnum"}, fail_testnum, 0);
        check({tag, ".cycles"}, cycles, 0);
        check({tag, ".pass_cnt"}, pass_cnt, 0);
        check({tag, ".fail_cnt"}, fail_cnt, 0);
    endtask

    task automatic monitor();
        logic done_q = 1'b0;
        verdict_t e;
        forever begin
            @(negedge clk);
            if (rst && done && !done_q) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL verdict: unexpected verdict at cycle %0d (pass=%0b fail=%0b timeout=%0b)",
                             cyc, pass, fail, timeout);
                end else begin
                    e = exp_q.pop_front();
                    check("v.at_cycle", cyc, e.at);
                    check("v.pass", pass, e.pass);
                    check("v.fail", fail, e.fail);
                    check("v.timeout", timeout, e.timeout);
                    check("v.fail_testnum", fail_testnum, e.tnum);
                    check("v.cycles", cycles, e.cycles);
                    check("v.pass_cnt", pass_cnt, e.pass_cnt);
                    check("v.fail_cnt", fail_cnt, e.fail_cnt);
                end
            end
            done_q = done;
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        check("rel.busy@0", busy, 0);
        step();
        check("rel.busy@1", busy, 1);
        check("rel.cycles@1", cycles, 1);

        // Pass: x27=1 at 40, x26=1 at 50
        wait_cyc(40); wr(5'd27, 1);
        wait_cyc(50); wr(5'd26, 1);
        expect_v(1, 0, 0, 0, 61, 1, 0, 61);
        wait_cyc(58);
        check("t1.settle_busy", busy, 1);
        check("t1.settle_done", done, 0);
        wait_cyc(65);
        check("t1.sticky_cycles", cycles, 61);
        check("t1.sticky_pass", pass, 1);

        // Fail with test number 7
        pulse_start();
        check_cleared("t2.start");
        check("t2.start_cycles", cycles, 0);
        wait_cyc(5); wr(5'd3, 7); wr(5'd27, 0); wr(5'd26, 1);
        expect_v(0, 1, 0, 7, 18, 1, 1, 18);
        wait_cyc(20);

        // Timeout with no done write
        pulse_start();
        check_cleared("t3.start");
        expect_v(0, 0, 1, 0, 99, 1, 2, 100);
        wait_cyc(110);
        check("t3.sticky_timeout", timeout, 1);
        check("t3.sticky_cycles", cycles, 99);

        // Done write in the timeout cycle wins
        pulse_start();
        wait_cyc(90); wr(5'd27, 1);
        wait_cyc(99); wr(5'd26, 1);
        check("t3b.no_timeout", timeout, 0);
        check("t3b.settle_busy", busy, 1);
        expect_v(1, 0, 0, 0, 110, 2, 2, 110);
        wait_cyc(112);

        // Late pass write during SETTLE is honoured
        pulse_start();
        wait_cyc(5); wr(5'd26, 1);
        wait_cyc(8); wr(5'd27, 1);
        expect_v(1, 0, 0, 0, 16, 3, 2, 16);
        wait_cyc(18);

        // Done write colliding with start, x0 write, done value 2: no verdict
        start = 1'b1;
        wb_we = 1'b1; wb_waddr = 5'd26; wb_wdata = 1;
        step();
        start = 1'b0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        wait_cyc(3); wr(5'd0, 1); wr(5'd26, 2);
        wait_cyc(30);
        check("t5.still_busy", busy, 1);
        check("t5.not_done", done, 0);
        check("t5.cycles", cycles, 30);

        // Asynchronous reset in the middle of SETTLE
        pulse_start();
        wait_cyc(2); wr(5'd26, 1);
        wait_cyc(6);
        check("t6.pre_busy", busy, 1);
        #1 rst = 1'b0;
        #1 check_all_zero("t6.async");
        #1 rst = 1'b1;
        step();
        check("t6.rel_busy", busy, 1);
        check("t6.rel_cycles", cycles, 1);

        // Back-to-back: pass, fail, pass from zeroed tallies
        wr(5'd3, 9); wr(5'd27, 1); wr(5'd26, 1);
        expect_v(1, 0, 0, 9, 14, 1, 0, 14);
        wait_cyc(16);
        pulse_start();
        check_cleared("b2b.start1");
        wait_cyc(1); wr(5'd3, 5); wr(5'd26, 1);
        expect_v(0, 1, 0, 5, 13, 1, 1, 13);
        wait_cyc(15);
        pulse_start();
        check_cleared("b2b.start2");
        wait_cyc(1); wr(5'd27, 1); wr(5'd26, 1);
        expect_v(1, 0, 0, 0, 13, 2, 1, 13);
        wait_cyc(15);
        check("b2b.pass_cnt", pass_cnt, 2);
        check("b2b.fail_cnt", fail_cnt, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
